// File: rtl/mac_4bit_pkg.sv
// Shared types and constants for the 4-bit multiply-accumulate stage.
package mac_4bit_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int unsigned N_TERMS_DEF = 4;
  localparam int unsigned ACC_W_DEF   = 12;

  // Bits needed to count 0 .. n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mac_4bit_seq_if.sv
// Operand-in / result-out handshake bundle for mac_4bit_seq.
interface mac_4bit_seq_if
  import mac_4bit_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, acc_out, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, acc_out, overflow
  );

endinterface

// File: rtl/mac_4bit_seq_mult.sv
// Combinational 4x4 unsigned multiplier feeding the MAC product register.
module multiplier_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Full 8-bit product, operands zero-extended first.
  always_comb begin
    p = {4'b0000, a} * {4'b0000, b};
  end

endmodule

// File: rtl/mac_4bit_seq.sv
// Sequential multiply-accumulate: sums every N_TERMS 4x4 products into one
// dot-product result, with valid/ready on both the operand and result sides.
module mac_4bit_seq
  import mac_4bit_pkg::*;
#(
  parameter int unsigned N_TERMS = N_TERMS_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  mac_4bit_seq_if.slave      bus
);

  localparam int unsigned      CNT_W = clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] term_cnt;
  logic [7:0]       mult_p;
  logic [7:0]       prod_q;
  logic             prod_v;
  logic             prod_first;
  logic             prod_last;
  logic [ACC_W-1:0] acc;
  logic             ov;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_nx;
  logic             ov_nx;
  logic             accept;
  logic             in_ready_c;
  logic             out_valid_q;
  logic [ACC_W-1:0] acc_out_q;
  logic             overflow_q;

  multiplier_4_bit u_mult (
    .a (bus.a),
    .b (bus.b),
    .p (mult_p)
  );

  // Handshake decode: ready purely from state, clr blocks any accept.
  always_comb begin
    in_ready_c = (state == COLLECT);
    accept     = bus.in_valid && in_ready_c && !clr;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.overflow  = overflow_q;

  // Next accumulator value; the final sum is also what lands in acc_out,
  // so it is formed combinationally and shared by both registers.
  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W + 1)'(prod_q);
    if (prod_first) begin
      acc_nx = ACC_W'(prod_q);
      ov_nx  = 1'b0;
    end else begin
      acc_nx = sum_ext[ACC_W-1:0];
      ov_nx  = ov | sum_ext[ACC_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nx;
  end

  // Next-state logic; clr overrides every handshake.
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (accept && (term_cnt == LAST)) state_nx = DRAIN;
        DRAIN:   state_nx = HOLD;
        HOLD:    if (bus.out_ready) state_nx = COLLECT;
        default: state_nx = COLLECT;
      endcase
    end
  end

  // Term counter and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_cnt   <= '0;
      prod_q     <= '0;
      prod_v     <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      prod_v <= accept;
      if (clr) begin
        term_cnt <= '0;
      end else if (accept) begin
        prod_q     <= mult_p;
        prod_first <= (term_cnt == '0);
        prod_last  <= (term_cnt == LAST);
        term_cnt   <= (term_cnt == LAST) ? '0 : term_cnt + 1'b1;
      end
    end
  end

  // Accumulator with sticky carry-out flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ov  <= 1'b0;
    end else if (prod_v && !clr) begin
      acc <= acc_nx;
      ov  <= ov_nx;
    end
  end

  // Result register: loads when the last product is folded in (the
  // DRAIN edge), released by out_ready in HOLD, dropped by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      overflow_q  <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
    end else if (prod_v && prod_last) begin
      out_valid_q <= 1'b1;
      acc_out_q   <= acc_nx;
      overflow_q  <= ov_nx;
    end else if ((state == HOLD) && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
